// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 set-2 prefix, state and ASCII constants
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] PS2_ENTER = 8'h5A;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - small character FIFO, write-enable in, valid/ready out
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_fire;
    logic             wr_fire;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign rd_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_fire  = wr_en && (!full || rd_fire) && !rst;
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // When full with a read, the written slot is the one being read out this cycle.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - set-2 scan codes to ASCII characters, buffered
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_code_strb,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       overflow
);

    prefix_state_t state;
    logic [7:0]    dec_data;
    logic          dec_we;
    logic          fifo_full;
    logic [7:0]    make_ascii;

    // Returns 8'h00 for any byte without a character mapping.
    function automatic logic [7:0] translate_make(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = ASCII_SP;
            8'h5A: a = ASCII_CR;
            8'h66: a = ASCII_BS;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign make_ascii = translate_make(scan_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dec_we   <= 1'b0;
            dec_data <= 8'h00;
        end else begin
            dec_we <= 1'b0;
            if (scan_code_strb) begin
                case (state)
                    ST_IDLE: begin
                        if (scan_code == PS2_EXT) begin
                            state <= ST_EXT;
                        end else if (scan_code == PS2_BRK) begin
                            state <= ST_BRK;
                        end else begin
                            dec_we   <= (make_ascii != 8'h00);
                            dec_data <= make_ascii;
                        end
                    end
                    ST_EXT: begin
                        if (scan_code == PS2_BRK) begin
                            state <= ST_EXT_BRK;
                        end else if (scan_code != PS2_EXT) begin
                            // Keypad Enter is the only extended key we keep.
                            if (scan_code == PS2_ENTER) begin
                                dec_we   <= 1'b1;
                                dec_data <= ASCII_CR;
                            end
                            state <= ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (scan_code == PS2_EXT)      state <= ST_EXT_BRK;
                        else if (scan_code != PS2_BRK) state <= ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        if (scan_code != PS2_EXT && scan_code != PS2_BRK) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (dec_we),
        .wr_data  (dec_data),
        .full     (fifo_full),
        .rd_data  (char_data),
        .rd_valid (char_valid),
        .rd_ready (char_ready)
    );

    // A full FIFO only drops the character when no read frees a slot this cycle.
    assign overflow = dec_we && fifo_full && !(char_valid && char_ready);

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - randomized and directed bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_code_strb = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready = 1'b0;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .scan_code      (scan_code),
        .scan_code_strb (scan_code_strb),
        .char_data      (char_data),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .overflow       (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: key map, prefix flags, pending decode, FIFO contents.
    logic [8:0] key_map [256];
    logic [7:0] q [$];
    logic       pend_v = 1'b0;
    logic [7:0] pend_c = 8'h00;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;

    task automatic build_map();
        logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
            8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,
            8'h1D,8'h22,8'h35,8'h1A};
        logic [7:0] digits [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
        for (int i = 0; i < 256; i++) key_map[i] = 9'h000;
        for (int i = 0; i < 26; i++) key_map[letters[i]] = {1'b1, 8'(8'h41 + i)};
        for (int i = 0; i < 10; i++) key_map[digits[i]] = {1'b1, 8'(8'h30 + i)};
        key_map[8'h29] = {1'b1, 8'h20};
        key_map[8'h5A] = {1'b1, 8'h0D};
        key_map[8'h66] = {1'b1, 8'h08};
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model at the edge.
    task automatic step(input logic [7:0] code, input bit strb, input bit ready, input bit r);
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_ovf;
        logic       fire;
        scan_code      = code;
        scan_code_strb = strb;
        char_ready     = ready;
        rst            = r;
        #1;
        exp_v   = (q.size() > 0);
        exp_d   = exp_v ? q[0] : 8'h00;
        fire    = exp_v && ready;
        exp_ovf = pend_v && (q.size() == DEPTH) && !fire;
        check_eq("char_valid", {31'd0, char_valid}, {31'd0, exp_v});
        check_eq("char_data", {24'd0, char_data}, {24'd0, exp_d});
        check_eq("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        @(posedge clk);
        if (r) begin
            q.delete();
            pend_v = 1'b0;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end else begin
            if (fire) void'(q.pop_front());
            if (pend_v && q.size() < DEPTH) q.push_back(pend_c);
            pend_v = 1'b0;
            if (strb) begin
                if (code == 8'hE0) m_ext = 1'b1;
                else if (code == 8'hF0) m_brk = 1'b1;
                else begin
                    if (!m_brk) begin
                        if (m_ext) begin
                            if (code == 8'h5A) begin pend_v = 1'b1; pend_c = 8'h0D; end
                        end else if (key_map[code][8]) begin
                            pend_v = 1'b1;
                            pend_c = key_map[code][7:0];
                        end
                    end
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, ready, 1'b0);
    endtask

    task automatic send(input logic [7:0] code, input bit ready);
        step(code, 1'b1, ready, 1'b0);
    endtask

    logic [7:0] pool [16] = '{8'hE0,8'hF0,8'h1C,8'h32,8'h5A,8'h75,8'h45,8'h29,
                              8'h66,8'hAA,8'hFA,8'h14,8'h1A,8'h16,8'hE1,8'h77};
    logic [7:0] rc;
    logic [7:0] stream [12] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B};

    initial begin
        build_map();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Make then break of A
        send(8'h1C, 1'b0); idle(3, 1'b0);
        send(8'hF0, 1'b1); send(8'h1C, 1'b1); idle(4, 1'b1);

        // Extended sequences
        send(8'hE0, 1'b1); send(8'h5A, 1'b1); idle(3, 1'b1);
        send(8'hE0, 1'b1); send(8'h75, 1'b1); idle(3, 1'b1);
        send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h5A, 1'b1); idle(3, 1'b1);
        send(8'h1C, 1'b1); idle(3, 1'b1);

        // Digits, space, backspace back to back
        send(8'h16, 1'b1); send(8'h45, 1'b1); send(8'h29, 1'b1); send(8'h66, 1'b1); idle(5, 1'b1);

        // Overflow on the fifth character, then drain
        send(8'h1C, 1'b0); send(8'h32, 1'b0); send(8'h21, 1'b0); send(8'h23, 1'b0); send(8'h24, 1'b0);
        idle(3, 1'b0); idle(6, 1'b1);

        // Stream across pointer wrap while full
        for (int i = 0; i < 4; i++) send(stream[i], 1'b0);
        idle(2, 1'b0);
        for (int i = 4; i < 12; i++) send(stream[i], 1'b1);
        idle(6, 1'b1);

        // Reset clears a pending break prefix
        send(8'hF0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        send(8'h1C, 1'b1); idle(4, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rc = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
            step(rc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 299) == 0));
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
